// File: rtl/sram_clr.sv
// sram_clr: single-port synchronous SRAM with a self-clearing start-up sequence.
// After reset the array is swept once, writing zero to every word. Requests are
// refused with an Err pulse until the sweep finishes.
//
// Request semantics: a request is the CS-qualified WE/RD pair sampled on a
// rising CLK edge. There is no backpressure. In READY every request is taken
// on the edge where it is presented. A read result is marked by a single-cycle
// Valid pulse RD_LAT cycles after that edge. DataOut changes only in a Valid
// cycle and holds its value in all other cycles.
module sram_clr #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CS,
    input  logic              WE,
    input  logic              RD,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Valid,
    output logic              Busy,
    output logic              Err,
    output logic              o_dbg_state   // 0 = CLEAR, 1 = READY
);

    localparam int DEPTH = 1 << ADDR_W;
    // Only 1 and 2 are meaningful. Any other value falls back to a single stage.
    localparam int LAT   = (RD_LAT == 2) ? 2 : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [LAT-1:0]    r_vld;
    logic [DATA_W-1:0] r_dat [LAT];
    logic              r_err;

    logic              w_ready;
    logic              w_req;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_err_nxt;
    logic              w_clr_last;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_ready    = (r_state == READY);
    assign w_req      = CS & (WE | RD);
    assign w_clr_last = (r_clr_cnt == {ADDR_W{1'b1}});

    // A write wins over a simultaneous read. The read half is dropped and flagged.
    assign w_wr_acc   = w_ready & CS & WE;
    assign w_rd_acc   = w_ready & CS & RD & ~WE;

    // Any request during the sweep is refused. In READY only the WE+RD
    // collision is refused.
    assign w_err_nxt  = w_req & (~w_ready | (WE & RD));

    // The sweep owns the write port while clearing. Writes are held off while
    // reset is applied so the sweep always starts cleanly from address 0.
    assign w_mem_we    = (~w_ready & ~RST) | w_wr_acc;
    assign w_mem_addr  = w_ready ? Addr   : r_clr_cnt;
    assign w_mem_wdata = w_ready ? DataIn : '0;

    // Next-state logic: leave CLEAR once the last word has been zeroed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (w_clr_last) w_state_nxt = READY;
            READY:   w_state_nxt = READY;
            default: w_state_nxt = CLEAR;
        endcase
    end

    // State register and clear address counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end else begin
                r_clr_cnt <= '0;
            end
        end
    end

    // Memory array write port. Contents are not reset. Only the sweep zeroes them.
    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Read pipeline. Stage 0 samples the array on the accepting edge. Each
    // later stage loads only when a valid word arrives, so the last stage
    // (DataOut) holds its value between reads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vld <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_dat[0] <= r_mem[Addr];
            end
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    // Error flag: a single-cycle pulse in the cycle after a refused request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign DataOut     = r_dat[LAT-1];
    assign Valid       = r_vld[LAT-1];
    assign Busy        = (r_state == CLEAR);
    assign Err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sram_clr.sv
// tb_sram_clr: directed bench for sram_clr.
// Two instances run side by side from the same stimulus: one with RD_LAT=1 and
// one with RD_LAT=2. Read expectations (data and arrival cycle) are queued when
// a read is driven. They are retired by a monitor on the falling edge.
module tb_sram_clr;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cs = 1'b0;
  logic       we = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;

  logic [7:0] dout1, dout2;
  logic       valid1, valid2, busy1, busy2, err1, err2, st1, st2;

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sram_clr #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1)) u_dut1 (
    .CLK(clk), .RST(rst), .CS(cs), .WE(we), .RD(rd), .Addr(addr), .DataIn(din),
    .DataOut(dout1), .Valid(valid1), .Busy(busy1), .Err(err1), .o_dbg_state(st1)
  );

  sram_clr #(.DATA_W(8), .ADDR_W(8), .RD_LAT(2)) u_dut2 (
    .CLK(clk), .RST(rst), .CS(cs), .WE(we), .RD(rd), .Addr(addr), .DataIn(din),
    .DataOut(dout2), .Valid(valid2), .Busy(busy2), .Err(err2), .o_dbg_state(st2)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q1[$];
  logic [7:0] exp_q2[$];
  int         exp_c1[$];
  int         exp_c2[$];
  logic [7:0] model_mem [256];
  int         err_cnt1 = 0;
  int         err_cnt2 = 0;
  logic [7:0] last1 = 8'h00;
  logic [7:0] last2 = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // scoreboard: retire read results, count Err pulses, check DataOut holds
  always @(negedge clk) begin
    if (rst) begin
      last1 = 8'h00;
      last2 = 8'h00;
    end else begin
      if (err1) err_cnt1++;
      if (err2) err_cnt2++;
      if (valid1) begin
        chk("valid1_expected", 32'(exp_q1.size() > 0), 1);
        if (exp_q1.size() > 0) begin
          chk("rd1_data", 32'(dout1), 32'(exp_q1.pop_front()));
          chk("rd1_cycle", cyc, exp_c1.pop_front());
        end
        last1 = dout1;
      end else begin
        chk("dout1_hold", 32'(dout1), 32'(last1));
      end
      if (valid2) begin
        chk("valid2_expected", 32'(exp_q2.size() > 0), 1);
        if (exp_q2.size() > 0) begin
          chk("rd2_data", 32'(dout2), 32'(exp_q2.pop_front()));
          chk("rd2_cycle", cyc, exp_c2.pop_front());
        end
        last2 = dout2;
      end else begin
        chk("dout2_hold", 32'(dout2), 32'(last2));
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cs = 1'b0; we = 1'b0; rd = 1'b0;
    end
  endtask

  task automatic wr_req(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b1; rd = 1'b0; addr = a; din = d;
    model_mem[a] = d;
  endtask

  task automatic rd_req(input logic [7:0] a);
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b0; rd = 1'b1; addr = a;
    exp_q1.push_back(model_mem[a]);
    exp_c1.push_back(cyc + 1);
    exp_q2.push_back(model_mem[a]);
    exp_c2.push_back(cyc + 2);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (exp_q1.size() > 0 || exp_q2.size() > 0); k++) begin
      @(posedge clk); #1;
    end
    chk("drain1", exp_q1.size(), 0);
    chk("drain2", exp_q2.size(), 0);
  endtask

  task automatic wait_clear(output int n1, output int n2);
    logic done;
    done = 1'b0;
    n1 = 0;
    n2 = 0;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (!busy1 && !busy2) begin
        done = 1'b1;
      end else begin
        n1 += int'(busy1);
        n2 += int'(busy2);
        cs = 1'b0; we = 1'b0; rd = 1'b0;
        if (k == 100) begin
          cs = 1'b1; we = 1'b1; addr = 8'h30; din = 8'h99;
        end
        if (k == 102) begin
          cs = 1'b1; rd = 1'b1; addr = 8'h30;
        end
      end
    end
    chk("clear_done", 32'(done), 1);
  endtask

  int n1, n2, e1, e2;

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_dout1", 32'(dout1), 0);
    chk("rst_dout2", 32'(dout2), 0);
    chk("rst_valid1", 32'(valid1), 0);
    chk("rst_valid2", 32'(valid2), 0);
    chk("rst_err1", 32'(err1), 0);
    chk("rst_err2", 32'(err2), 0);
    chk("rst_busy1", 32'(busy1), 1);
    chk("rst_busy2", 32'(busy2), 1);
    chk("rst_state1", 32'(st1), 0);

    // post-reset clear with two refused requests part-way through
    @(posedge clk); #1;
    rst = 1'b0;
    err_cnt1 = 0;
    err_cnt2 = 0;
    wait_clear(n1, n2);
    chk("busy1_cycles", n1, 256);
    chk("busy2_cycles", n2, 256);
    idle(2);
    chk("busy_err1", err_cnt1, 2);
    chk("busy_err2", err_cnt2, 2);
    chk("ready_state1", 32'(st1), 1);

    // cleared contents, including the address targeted during Busy
    rd_req(8'h00);
    rd_req(8'h7F);
    rd_req(8'hFF);
    rd_req(8'h30);
    idle(1);
    drain();

    // write then back-to-back reads
    wr_req(8'h0A, 8'h0A);
    wr_req(8'h14, 8'h14);
    wr_req(8'h1E, 8'h1E);
    wr_req(8'h28, 8'h28);
    rd_req(8'h0A);
    rd_req(8'h14);
    rd_req(8'h1E);
    rd_req(8'h28);
    idle(1);
    drain();

    // read directly after a write to the same address
    wr_req(8'h40, 8'h77);
    rd_req(8'h40);
    idle(1);
    drain();

    // WE+RD collision: write lands, read dropped, Err pulses
    e1 = err_cnt1;
    e2 = err_cnt2;
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b1; rd = 1'b1; addr = 8'h05; din = 8'h55;
    model_mem[8'h05] = 8'h55;
    idle(3);
    chk("conflict_err1", err_cnt1 - e1, 1);
    chk("conflict_err2", err_cnt2 - e2, 1);
    rd_req(8'h05);
    idle(1);
    drain();

    // CS gating: deselected write is silently ignored
    wr_req(8'h10, 8'h3C);
    idle(1);
    e1 = err_cnt1;
    e2 = err_cnt2;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b1; rd = 1'b0; addr = 8'h10; din = 8'hAA;
    @(posedge clk); #1;
    cs = 1'b0; we = 1'b0; rd = 1'b1; addr = 8'h10;
    idle(3);
    chk("cs0_err1", err_cnt1 - e1, 0);
    chk("cs0_err2", err_cnt2 - e2, 0);
    rd_req(8'h10);
    idle(1);
    drain();

    // reset one cycle after a read request: the read never completes
    @(posedge clk); #1;
    cs = 1'b1; we = 1'b0; rd = 1'b1; addr = 8'h0A;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid1", 32'(valid1), 0);
    chk("midrst_valid2", 32'(valid2), 0);
    chk("midrst_dout1", 32'(dout1), 0);
    chk("midrst_dout2", 32'(dout2), 0);
    chk("midrst_busy1", 32'(busy1), 1);
    chk("midrst_busy2", 32'(busy2), 1);
    @(negedge clk);
    chk("midrst_valid2_late", 32'(valid2), 0);
    for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    @(posedge clk); #1;
    rst = 1'b0;
    err_cnt1 = 0;
    err_cnt2 = 0;
    wait_clear(n1, n2);
    chk("reclear1_cycles", n1, 256);
    chk("reclear2_cycles", n2, 256);
    idle(1);

    // previously written addresses read back as zero
    rd_req(8'h0A);
    rd_req(8'h14);
    rd_req(8'h05);
    rd_req(8'h10);
    rd_req(8'h40);
    idle(1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
